// File: rtl/seq_shifter.sv
// seq_shifter
//   Multi-cycle shift unit: applies a 0..(2**CNTW-1) position shift one bit
//   per clock, with logical/arithmetic left/right modes, carry-out of the
//   last bit shifted out and sticky arithmetic-left overflow.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset
//   start : request; only sampled while idle
//   op    : 00 logical left, 01 logical right, 10 arithmetic left,
//           11 arithmetic right
//   A     : operand, captured on accept
//   amt   : shift distance, captured on accept
//   busy  : high while shifting (exactly amt cycles)
//   done  : one-cycle pulse, result valid
//   Y     : result, held until the next accept
//   cout  : last bit shifted out (0 when amt = 0)
//   ovf   : arithmetic-left overflow, sticky for the operation
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [CNTW-1:0]  amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASL = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    state_t            state, state_nx;
    logic [CNTW-1:0]   cnt;
    logic [1:0]        op_r;
    logic [WIDTH-1:0]  step_y;
    logic              step_c;
    logic              step_v;

    // State register; busy/done are flopped from the next state so both
    // are clean registered outputs aligned with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == SHIFT);
            done  <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == CNTW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One-bit step of the current result.
    always_comb begin
        step_y = Y;
        step_c = 1'b0;
        step_v = 1'b0;
        case (op_r)
            OP_LSL: begin
                step_y = {Y[WIDTH-2:0], 1'b0};
                step_c = Y[WIDTH-1];
            end
            OP_LSR: begin
                step_y = {1'b0, Y[WIDTH-1:1]};
                step_c = Y[0];
            end
            OP_ASL: begin
                step_y = {Y[WIDTH-2:0], 1'b0};
                step_c = Y[WIDTH-1];
                step_v = Y[WIDTH-1] ^ Y[WIDTH-2];
            end
            OP_ASR: begin
                step_y = {Y[WIDTH-1], Y[WIDTH-1:1]};
                step_c = Y[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y    <= '0;
            cnt  <= '0;
            op_r <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        Y    <= A;
                        cnt  <= amt;
                        op_r <= op;
                        cout <= 1'b0;
                        ovf  <= 1'b0;
                    end
                end
                SHIFT: begin
                    Y    <= step_y;
                    cnt  <= cnt - CNTW'(1);
                    cout <= step_c;
                    ovf  <= ovf | step_v;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    typedef struct {
        logic [15:0] y;
        logic        c;
        logic        v;
        int          n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] A;
    logic [3:0]  amt;
    logic        busy, done, cout, ovf;
    logic [15:0] Y;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    seq_shifter #(.WIDTH(16), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .amt(amt),
        .busy(busy), .done(done), .Y(Y), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Closed-form reference of an n-step shift.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input int n);
        exp_t e;
        e.n = n;
        e.v = 1'b0;
        e.c = 1'b0;
        case (o)
            2'b00, 2'b10: begin
                e.y = a << n;
                if (n > 0) e.c = a[16-n];
            end
            2'b01: begin
                e.y = a >> n;
                if (n > 0) e.c = a[n-1];
            end
            default: begin
                e.y = 16'($signed(a) >>> n);
                if (n > 0) e.c = a[n-1];
            end
        endcase
        // Left arithmetic overflow: top n+1 bits of the operand not all equal.
        if (o == 2'b10 && n > 0)
            for (int i = 15 - n; i < 15; i++)
                if (a[i] != a[15]) e.v = 1'b1;
        return e;
    endfunction

    task automatic do_op(input string nm, input logic [1:0] o, input logic [15:0] a,
                         input logic [3:0] n, input bit poke_start);
        exp_t e;
        int   lat, bcnt;
        bit   seen;
        logic [15:0] yh;
        sbq.push_back(model(o, a, int'(n)));
        @(negedge clk);
        op = o; A = a; amt = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; A = ~a; amt = 4'($urandom);
        lat = 0; bcnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy) bcnt++;
            if (done) seen = 1;
            else begin
                if (poke_start && i == 2) begin
                    op = 2'b00; A = 16'hFFFF; amt = 4'd1; start = 1'b1;
                end
                @(posedge clk); #1;
                start = 1'b0;
                lat++;
            end
        end
        e = sbq.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout: done not seen within 40 cycles", nm);
            return;
        end
        checks++;
        if (Y !== e.y) begin failures++; $display("FAIL %s Y: got %h want %h", nm, Y, e.y); end
        checks++;
        if (cout !== e.c) begin failures++; $display("FAIL %s cout: got %b want %b", nm, cout, e.c); end
        checks++;
        if (ovf !== e.v) begin failures++; $display("FAIL %s ovf: got %b want %b", nm, ovf, e.v); end
        checks++;
        if (lat != e.n) begin failures++; $display("FAIL %s latency: got %0d want %0d", nm, lat, e.n); end
        checks++;
        if (bcnt != e.n) begin failures++; $display("FAIL %s busy cycles: got %0d want %0d", nm, bcnt, e.n); end
        yh = Y;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || Y !== e.y) begin
            failures++;
            $display("FAIL %s after done: done=%b busy=%b Y=%h want done=0 busy=0 Y=%h", nm, done, busy, Y, e.y);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; A = '0; amt = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, cout, ovf} !== 4'b0 || Y !== 16'h0000) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b cout=%b ovf=%b Y=%h want all 0", busy, done, cout, ovf, Y);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_logical();
        do_op("lsl_1_4",   2'b00, 16'h0001, 4'd4, 0);
        do_op("lsr_8001",  2'b01, 16'h8001, 4'd1, 0);
        do_op("lsl_8000",  2'b00, 16'h8000, 4'd1, 0);
    endtask

    task automatic test_arith_right();
        do_op("asr_15",    2'b11, 16'h8000, 4'd15, 0);
        do_op("asr_7ff0",  2'b11, 16'h7FF0, 4'd4, 0);
    endtask

    task automatic test_arith_left();
        do_op("asl_4000",  2'b10, 16'h4000, 4'd1, 0);
        do_op("asl_0001",  2'b10, 16'h0001, 4'd3, 0);
        do_op("asl_c000",  2'b10, 16'hC000, 4'd2, 0);
    endtask

    task automatic test_zero_and_ignored_start();
        do_op("amt0",      2'b11, 16'h1234, 4'd0, 0);
        do_op("poke_busy", 2'b01, 16'hA5C3, 4'd5, 1);
    endtask

    task automatic test_reset_mid_shift();
        bit got_done;
        @(negedge clk);
        op = 2'b00; A = 16'h00FF; amt = 4'd10; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b1; start = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, ovf} !== 4'b0 || Y !== 16'h0000) begin
            failures++;
            $display("FAIL rst_mid: busy=%b done=%b cout=%b ovf=%b Y=%h want all 0", busy, done, cout, ovf, Y);
        end
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        got_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) got_done = 1;
        end
        checks++;
        if (got_done) begin
            failures++;
            $display("FAIL rst_mid_quiet: activity after reset got 1 want 0");
        end
        do_op("after_rst", 2'b00, 16'h0003, 4'd2, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++)
            do_op("rand", 2'($urandom), 16'($urandom), 4'($urandom), 0);
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith_right();
        test_arith_left();
        test_zero_and_ignored_start();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
